// File: rtl/i2c_reg_access_ctrl_pkg.sv
// i2c_reg_access_ctrl_pkg: shared state encodings, ACK constants and address decode helper
package i2c_reg_access_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DEV  = 3'd1,
        ST_PTR  = 3'd2,
        ST_WR   = 3'd3,
        ST_RD   = 3'd4,
        ST_IGN  = 3'd5
    } state_t;

    localparam logic       ACK          = 1'b1;
    localparam logic       NACK         = 1'b0;
    localparam logic [6:0] DEF_DEV_ADDR = 7'h3C;

    function automatic logic addr_match(input logic [7:0] b, input logic [6:0] dev);
        return b[7:1] == dev;
    endfunction

endpackage

// File: rtl/i2c_addr_ptr.sv
// i2c_addr_ptr: 8-bit register pointer, load beats increment, wraps modulo 256
module i2c_addr_ptr (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       inc,
    output logic [7:0] ptr
);

    logic [7:0] r_ptr;

    always_ff @(posedge clk) begin
        if (rst)
            r_ptr <= 8'h00;
        else
            r_ptr <= load ? load_val : inc ? r_ptr + 8'h01 : r_ptr;
    end

    assign ptr = r_ptr;

endmodule

// File: rtl/i2c_reg_access_ctrl.sv
// i2c_reg_access_ctrl: byte-level I2C slave transaction controller between the serial
// engine and a register bank with combinational read data.
module i2c_reg_access_ctrl
    import i2c_reg_access_ctrl_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = DEF_DEV_ADDR,
    parameter bit         AUTO_INC = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_det,
    input  logic       stop_det,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    input  logic       tx_req,
    output logic       ack,
    output logic       ack_valid,
    output logic [7:0] tx_byte,
    output logic       tx_valid,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    input  logic [7:0] reg_rdata
);

    state_t     r_state;
    logic       r_rw;
    logic       r_ack;
    logic       r_ack_valid;
    logic [7:0] r_tx_byte;
    logic       r_tx_valid;
    logic [7:0] r_reg_wdata;
    logic       r_reg_we;
    logic       w_go;
    logic       w_rx;
    logic       w_tx;
    logic       w_load;
    logic       w_inc;

    // START and STOP pre-empt any byte event arriving in the same cycle
    assign w_go   = !start_det && !stop_det;
    assign w_rx   = w_go && rx_valid && r_state != ST_IDLE;
    assign w_tx   = w_go && tx_req && r_state == ST_RD && r_rw;
    assign w_load = w_rx && r_state == ST_PTR;
    // the write strobe cycle still presents the old pointer, so advance on that edge
    assign w_inc  = AUTO_INC && (r_reg_we || w_tx);

    i2c_addr_ptr u_ptr (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (rx_byte),
        .inc      (w_inc),
        .ptr      (reg_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rw        <= 1'b0;
            r_ack       <= NACK;
            r_ack_valid <= 1'b0;
            r_tx_byte   <= 8'h00;
            r_tx_valid  <= 1'b0;
            r_reg_wdata <= 8'h00;
            r_reg_we    <= 1'b0;
        end else begin
            r_ack_valid <= w_rx;
            r_tx_valid  <= w_tx;
            r_reg_we    <= w_rx && r_state == ST_WR;
            if (start_det)
                r_state <= ST_DEV;
            else if (stop_det)
                r_state <= ST_IDLE;
            else if (w_rx) begin
                case (r_state)
                    ST_DEV: begin
                        r_ack   <= addr_match(rx_byte, DEV_ADDR) ? ACK : NACK;
                        r_rw    <= addr_match(rx_byte, DEV_ADDR) ? rx_byte[0] : r_rw;
                        r_state <= !addr_match(rx_byte, DEV_ADDR) ? ST_IGN :
                                   rx_byte[0] ? ST_RD : ST_PTR;
                    end
                    ST_PTR: begin
                        r_ack   <= ACK;
                        r_state <= ST_WR;
                    end
                    ST_WR: begin
                        r_ack       <= ACK;
                        r_reg_wdata <= rx_byte;
                    end
                    default: r_ack <= NACK;
                endcase
            end
            if (w_tx)
                r_tx_byte <= reg_rdata;
        end
    end

    assign ack       = r_ack;
    assign ack_valid = r_ack_valid;
    assign tx_byte   = r_tx_byte;
    assign tx_valid  = r_tx_valid;
    assign reg_wdata = r_reg_wdata;
    assign reg_we    = r_reg_we;

endmodule

// File: tb/tb_i2c_reg_access_ctrl.sv
// tb_i2c_reg_access_ctrl: directed bench driving engine pulses into two controllers
// (auto-increment on and off) each backed by its own 256x8 bank model.
module tb_i2c_reg_access_ctrl;
    import i2c_reg_access_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       bank_init;
    logic       start_det;
    logic       stop_det;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       tx_req;

    logic       ack, ack_valid, tx_valid, reg_we;
    logic [7:0] tx_byte, reg_addr, reg_wdata, reg_rdata;
    logic       ack0, ack_valid0, tx_valid0, reg_we0;
    logic [7:0] tx_byte0, reg_addr0, reg_wdata0, reg_rdata0;

    logic [7:0] bank  [256];
    logic [7:0] bank0 [256];
    int         wr_cnt;
    int         wr_cnt0;
    int         n_cmp = 0;
    int         n_err = 0;
    int         snap;
    int         snap0;

    always #5 clk = ~clk;

    i2c_reg_access_ctrl #(.DEV_ADDR(7'h3C), .AUTO_INC(1'b1)) u_dut (
        .clk(clk), .rst(rst), .start_det(start_det), .stop_det(stop_det),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .tx_req(tx_req),
        .ack(ack), .ack_valid(ack_valid), .tx_byte(tx_byte), .tx_valid(tx_valid),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_rdata(reg_rdata)
    );

    i2c_reg_access_ctrl #(.DEV_ADDR(7'h3C), .AUTO_INC(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .start_det(start_det), .stop_det(stop_det),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .tx_req(tx_req),
        .ack(ack0), .ack_valid(ack_valid0), .tx_byte(tx_byte0), .tx_valid(tx_valid0),
        .reg_addr(reg_addr0), .reg_wdata(reg_wdata0), .reg_we(reg_we0), .reg_rdata(reg_rdata0)
    );

    assign reg_rdata  = bank[reg_addr];
    assign reg_rdata0 = bank0[reg_addr0];

    always @(posedge clk) begin
        if (bank_init) begin
            for (int i = 0; i < 256; i++) bank[i] <= ~8'(i);
            wr_cnt <= 0;
        end else if (reg_we) begin
            bank[reg_addr] <= reg_wdata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    always @(posedge clk) begin
        if (bank_init) begin
            for (int i = 0; i < 256; i++) bank0[i] <= ~8'(i);
            wr_cnt0 <= 0;
        end else if (reg_we0) begin
            bank0[reg_addr0] <= reg_wdata0;
            wr_cnt0 <= wr_cnt0 + 1;
        end
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_start;
        start_det = 1'b1;
        tick();
        start_det = 1'b0;
    endtask

    task automatic send_stop;
        stop_det = 1'b1;
        tick();
        stop_det = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_tx;
        tx_req = 1'b1;
        tick();
        tx_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; bank_init = 1'b1;
        start_det = 1'b0; stop_det = 1'b0; rx_byte = 8'h00; rx_valid = 1'b0; tx_req = 1'b0;
        repeat (3) tick();
        rst = 1'b0; bank_init = 1'b0;

        check("rst_ack_valid", 8'(ack_valid), 8'h00);
        check("rst_ack",       8'(ack),       8'h00);
        check("rst_reg_we",    8'(reg_we),    8'h00);
        check("rst_tx_valid",  8'(tx_valid),  8'h00);
        check("rst_tx_byte",   tx_byte,       8'h00);
        check("rst_reg_wdata", reg_wdata,     8'h00);
        check("rst_reg_addr",  reg_addr,      8'h00);
        check("rst_state",     8'(u_dut.r_state), 8'(ST_IDLE));

        send_rx(8'h78);
        check("idle_no_ack", 8'(ack_valid), 8'h00);

        // 1: simple write
        send_start();
        check("t1_state_dev", 8'(u_dut.r_state), 8'(ST_DEV));
        send_rx(8'h78);
        check("t1_dev_av",  8'(ack_valid), 8'h01);
        check("t1_dev_ack", 8'(ack), 8'h01);
        check("t1_state_ptr", 8'(u_dut.r_state), 8'(ST_PTR));
        send_rx(8'h05);
        check("t1_ptr_ack", 8'(ack), 8'h01);
        check("t1_ptr_load", reg_addr, 8'h05);
        send_rx(8'hA5);
        check("t1_wr_ack", 8'(ack), 8'h01);
        check("t1_we",     8'(reg_we), 8'h01);
        check("t1_waddr",  reg_addr, 8'h05);
        check("t1_wdata",  reg_wdata, 8'hA5);
        send_stop();
        check("t1_we_off",  8'(reg_we), 8'h00);
        check("t1_wr_cnt",  8'(wr_cnt), 8'h01);
        check("t1_bank5",   bank[8'h05], 8'hA5);
        check("t1_ptr",     reg_addr, 8'h06);
        check("t1_idle",    8'(u_dut.r_state), 8'(ST_IDLE));

        // 2: combined format read with repeated START
        send_start();
        send_rx(8'h78);
        send_rx(8'h02);
        send_start();
        send_rx(8'h79);
        check("t2_rd_ack", 8'(ack), 8'h01);
        check("t2_state_rd", 8'(u_dut.r_state), 8'(ST_RD));
        send_tx();
        check("t2_tv0", 8'(tx_valid), 8'h01);
        check("t2_tx0", tx_byte, 8'hFD);
        send_tx();
        check("t2_tx1", tx_byte, 8'hFC);
        send_rx(8'h55);
        check("t2_rx_in_rd_ack", 8'(ack), 8'h00);
        send_tx();
        check("t2_tx2", tx_byte, 8'hFB);
        tick();
        check("t2_tv_off", 8'(tx_valid), 8'h00);
        check("t2_ptr", reg_addr, 8'h05);
        send_stop();

        // 3: wrong device address
        snap = wr_cnt;
        send_start();
        send_rx(8'h7A);
        check("t3_av",   8'(ack_valid), 8'h01);
        check("t3_nack", 8'(ack), 8'h00);
        check("t3_ign",  8'(u_dut.r_state), 8'(ST_IGN));
        send_rx(8'h11);
        check("t3_nack2", 8'(ack), 8'h00);
        send_tx();
        check("t3_no_tx", 8'(tx_valid), 8'h00);
        tick();
        check("t3_no_we", 8'(wr_cnt - snap), 8'h00);
        check("t3_still_ign", 8'(u_dut.r_state), 8'(ST_IGN));
        send_stop();
        check("t3_idle", 8'(u_dut.r_state), 8'(ST_IDLE));

        // 4: back-to-back writes across pointer wrap
        send_start();
        send_rx(8'h78);
        send_rx(8'hFE);
        send_rx(8'h10);
        send_rx(8'h20);
        send_rx(8'h30);
        send_stop();
        check("t4_bankFE", bank[8'hFE], 8'h10);
        check("t4_bankFF", bank[8'hFF], 8'h20);
        check("t4_bank00", bank[8'h00], 8'h30);
        check("t4_ptr",    reg_addr, 8'h01);

        // 5: START collides with rx_valid, then reset aborts a write
        send_start();
        start_det = 1'b1; rx_byte = 8'h78; rx_valid = 1'b1;
        tick();
        start_det = 1'b0; rx_valid = 1'b0;
        check("t5_no_av",  8'(ack_valid), 8'h00);
        check("t5_dev",    8'(u_dut.r_state), 8'(ST_DEV));
        send_rx(8'h78);
        send_rx(8'h33);
        check("t5_ptr33", reg_addr, 8'h33);
        snap = wr_cnt;
        rst = 1'b1; rx_byte = 8'h44; rx_valid = 1'b1;
        tick();
        rst = 1'b0; rx_valid = 1'b0;
        check("t5_we_cancel", 8'(reg_we), 8'h00);
        check("t5_ptr_rst",   reg_addr, 8'h00);
        check("t5_state_rst", 8'(u_dut.r_state), 8'(ST_IDLE));
        tick();
        check("t5_no_write", 8'(wr_cnt - snap), 8'h00);
        check("t5_bank33",   bank[8'h33], 8'hCC);

        // 6: AUTO_INC=0 keeps pointer fixed
        snap  = wr_cnt;
        snap0 = wr_cnt0;
        send_start();
        send_rx(8'h78);
        send_rx(8'h09);
        send_rx(8'h01);
        check("t6_we0",   8'(reg_we0), 8'h01);
        check("t6_addr0", reg_addr0, 8'h09);
        send_rx(8'h02);
        check("t6_addr0b", reg_addr0, 8'h09);
        send_stop();
        check("t6_bank0_9", bank0[8'h09], 8'h02);
        check("t6_wr_cnt0", 8'(wr_cnt0 - snap0), 8'h02);
        check("t6_ptr0",    reg_addr0, 8'h09);
        check("t6_ptr1",    reg_addr, 8'h0B);
        check("t6_bank_A",  bank[8'h0A], 8'h02);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
